// File: rtl/spi_cfg_master_if.sv
// Register-write request bundle for spi_cfg_master.
// Two independent requesters (A and B) each present valid/addr/data and
// receive ready. A write is accepted in the cycle where valid && ready.
// The master modport belongs to the requester side and the slave modport
// to the SPI configuration master.
interface spi_cfg_master_if;
   logic       a_valid;
   logic [6:0] a_addr;
   logic [7:0] a_data;
   logic       a_ready;
   logic       b_valid;
   logic [6:0] b_addr;
   logic [7:0] b_data;
   logic       b_ready;

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      output a_ready, b_ready
   );
endinterface

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: two-requester SPI register-write master.
// Requests are arbitrated round-robin and accepted only in IDLE. Each accepted
// write is sent as one 16-bit frame {1'b1, addr, data}, MSB first, in SPI
// mode 0. One half-period counter times every phase of the frame. SETUP,
// SHIFT_HI, SHIFT_LO and HOLD last CLK_DIV cycles each, and GAP lasts
// 2*CLK_DIV cycles. A 4-bit index selects the bit on copi. All SPI pins and
// status outputs are registered. Only the ready signals are combinational.
// CLK_DIV must lie in 4..1023 so that the 11-bit counter covers the gap.
module spi_cfg_master #(
   parameter int unsigned CLK_DIV = 50
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_cfg_master_if.slave req,
   output logic            ncs,
   output logic            sclk,
   output logic            copi,
   output logic            busy,
   output logic            done,
   output logic            done_id
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      SHIFT_HI = 3'd2,
      SHIFT_LO = 3'd3,
      HOLD     = 3'd4,
      GAP      = 3'd5
   } state_t;

   localparam int unsigned CNT_W     = 11;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((2 * CLK_DIV) - 1);

   // Write frame: the leading 1 marks a register write.
   function automatic logic [15:0] make_frame(input logic [6:0] addr,
                                              input logic [7:0] data);
      return {1'b1, addr, data};
   endfunction

   // FSM and datapath state
   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [3:0]       bit_idx_r;
   logic [3:0]       bit_idx_nxt_s;
   logic [15:0]      frame_r;
   logic [15:0]      frame_nxt_s;
   logic             id_r;
   logic             id_nxt_s;
   logic             last_b_r;
   logic             last_b_nxt_s;

   // Arbitration and request selection
   logic             grant_a_s;
   logic             grant_b_s;
   logic             accept_s;
   logic [6:0]       sel_addr_s;
   logic [7:0]       sel_data_s;

   // Phase timing
   logic             half_tc_s;
   logic             gap_tc_s;

   // Registered outputs and their next values
   logic             ncs_r;
   logic             sclk_r;
   logic             copi_r;
   logic             busy_r;
   logic             done_r;
   logic             done_id_r;
   logic             ncs_nxt_s;
   logic             sclk_nxt_s;
   logic             copi_nxt_s;
   logic             busy_nxt_s;
   logic             done_nxt_s;
   logic             done_id_nxt_s;

   assign half_tc_s = (cnt_r == HALF_LAST);
   assign gap_tc_s  = (cnt_r == GAP_LAST);

   // Round-robin grant. It is offered only in IDLE and outside reset, so a
   // request can never be taken while reset discards it. A wins a tie only
   // when B was served last.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (rst_n && (state_r == IDLE)) begin
         if (req.a_valid && (!req.b_valid || last_b_r)) begin
            grant_a_s = 1'b1;
         end else if (req.b_valid) begin
            grant_b_s = 1'b1;
         end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
         end
      end else begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end
   end

   assign req.a_ready = grant_a_s;
   assign req.b_ready = grant_b_s;
   assign accept_s    = grant_a_s | grant_b_s;

   // Select the address and data of the granted requester.
   always_comb begin
      sel_addr_s = req.a_addr;
      sel_data_s = req.a_data;
      if (grant_b_s) begin
         sel_addr_s = req.b_addr;
         sel_data_s = req.b_data;
      end else begin
         sel_addr_s = req.a_addr;
         sel_data_s = req.a_data;
      end
   end

   // Next-state logic. Each phase advances on terminal count of the shared
   // counter.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = SETUP;
            else          state_nxt_s = IDLE;
         end
         SETUP: begin
            if (half_tc_s) state_nxt_s = SHIFT_HI;
            else           state_nxt_s = SETUP;
         end
         SHIFT_HI: begin
            if (!half_tc_s)               state_nxt_s = SHIFT_HI;
            else if (bit_idx_r == 4'd15)  state_nxt_s = HOLD;
            else                          state_nxt_s = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (half_tc_s) state_nxt_s = SHIFT_HI;
            else           state_nxt_s = SHIFT_LO;
         end
         HOLD: begin
            if (half_tc_s) state_nxt_s = GAP;
            else           state_nxt_s = HOLD;
         end
         GAP: begin
            if (gap_tc_s) state_nxt_s = IDLE;
            else          state_nxt_s = GAP;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath next values. The counter restarts on every state change. The
   // bit index steps on each falling SCLK. The frame, id and last grant are
   // captured on accept.
   always_comb begin
      if ((state_r == IDLE) || (state_nxt_s != state_r)) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (accept_s) begin
         bit_idx_nxt_s = 4'd0;
      end else if ((state_r == SHIFT_HI) && (state_nxt_s == SHIFT_LO)) begin
         bit_idx_nxt_s = bit_idx_r + 4'd1;
      end else begin
         bit_idx_nxt_s = bit_idx_r;
      end

      if (accept_s) begin
         frame_nxt_s  = make_frame(sel_addr_s, sel_data_s);
         id_nxt_s     = grant_b_s;
         last_b_nxt_s = grant_b_s;
      end else begin
         frame_nxt_s  = frame_r;
         id_nxt_s     = id_r;
         last_b_nxt_s = last_b_r;
      end
   end

   // Output decode from the next state. The outputs are registered, so the
   // pins line up with the state register. copi only moves when the next
   // state has sclk low.
   always_comb begin
      ncs_nxt_s  = 1'b1;
      sclk_nxt_s = 1'b0;
      copi_nxt_s = 1'b0;
      case (state_nxt_s)
         IDLE, GAP: begin
            ncs_nxt_s  = 1'b1;
            sclk_nxt_s = 1'b0;
            copi_nxt_s = 1'b0;
         end
         SETUP, SHIFT_LO, HOLD: begin
            ncs_nxt_s  = 1'b0;
            sclk_nxt_s = 1'b0;
            copi_nxt_s = frame_nxt_s[4'd15 - bit_idx_nxt_s];
         end
         SHIFT_HI: begin
            ncs_nxt_s  = 1'b0;
            sclk_nxt_s = 1'b1;
            copi_nxt_s = frame_nxt_s[4'd15 - bit_idx_nxt_s];
         end
         default: begin
            ncs_nxt_s  = 1'b1;
            sclk_nxt_s = 1'b0;
            copi_nxt_s = 1'b0;
         end
      endcase

      busy_nxt_s = (state_nxt_s != IDLE);
      done_nxt_s = (state_r == HOLD) && (state_nxt_s == GAP);
      if (done_nxt_s) begin
         done_id_nxt_s = id_r;
      end else begin
         done_id_nxt_s = done_id_r;
      end
   end

   // State and datapath registers. A synchronous reset aborts any frame and
   // drops the latched request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         bit_idx_r <= 4'd0;
         frame_r   <= 16'h0000;
         id_r      <= 1'b0;
         last_b_r  <= 1'b1;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         bit_idx_r <= bit_idx_nxt_s;
         frame_r   <= frame_nxt_s;
         id_r      <= id_nxt_s;
         last_b_r  <= last_b_nxt_s;
      end
   end

   // Output registers. Reset forces the idle pin levels with no done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ncs_r     <= 1'b1;
         sclk_r    <= 1'b0;
         copi_r    <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         done_id_r <= 1'b0;
      end else begin
         ncs_r     <= ncs_nxt_s;
         sclk_r    <= sclk_nxt_s;
         copi_r    <= copi_nxt_s;
         busy_r    <= busy_nxt_s;
         done_r    <= done_nxt_s;
         done_id_r <= done_id_nxt_s;
      end
   end

   assign ncs     = ncs_r;
   assign sclk    = sclk_r;
   assign copi    = copi_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign done_id = done_id_r;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Self-checking bench for spi_cfg_master with CLK_DIV=4.
// A cycle model of the grant and busy timing pushes the expected frames into
// a scoreboard. An SPI receiver on the pins pops them at ncs rise and feeds a
// small peripheral register block.
module tb_spi_cfg_master;
   localparam int D        = 4;
   localparam int BUSY_CYC = 35 * D;
   localparam int BUDGET   = 400 * D;

   typedef struct packed {
      logic        id;
      logic [15:0] frame;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ncs, sclk, copi, busy, done, done_id;

   spi_cfg_master_if bus ();

   spi_cfg_master #(.CLK_DIV(D)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.slave),
      .ncs     (ncs),
      .sclk    (sclk),
      .copi    (copi),
      .busy    (busy),
      .done    (done),
      .done_id (done_id)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   exp_t sb [$];
   logic got_ids [$];
   logic [7:0] pregs [0:4];

   int   left         = 0;
   logic model_last_b = 1'b1;
   int   grants       = 0;

   logic        prev_ncs  = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        prev_copi = 1'b0;
   logic [15:0] shift     = 16'h0000;
   int          edges     = 0;
   int          low_cnt   = 0;
   int          high_cnt  = 0;
   int          frames    = 0;
   int          done_cnt  = 0;
   bit          gap_check = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Grant/busy model: checks the ready and busy signals every cycle and pushes the expected frame on each grant.
   initial begin : model
      logic ea;
      logic eb;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            left         = 0;
            model_last_b = 1'b1;
         end else begin
            ea = (left == 0) && bus.a_valid && (!bus.b_valid || model_last_b);
            eb = (left == 0) && bus.b_valid && !ea;
            chk("a_ready", 32'(bus.a_ready), 32'(ea));
            chk("b_ready", 32'(bus.b_ready), 32'(eb));
            chk("busy", 32'(busy), 32'(left != 0));
            if (left > 0) left--;
            if (ea || eb) begin
               e.id    = eb;
               e.frame = ea ? {1'b1, bus.a_addr, bus.a_data} : {1'b1, bus.b_addr, bus.b_data};
               sb.push_back(e);
               model_last_b = eb;
               left         = BUSY_CYC;
               grants++;
            end
         end
      end
   end

   // SPI receiver and peripheral register block: decodes the pins, scores each frame and checks the done pulse.
   initial begin : spi_mon
      logic ncs_rise;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ncs  = 1'b1;
            prev_sclk = 1'b0;
            prev_copi = 1'b0;
            edges     = 0;
            low_cnt   = 0;
            high_cnt  = 0;
            shift     = 16'h0000;
            sb.delete();
         end else begin
            ncs_rise = !prev_ncs && (ncs === 1'b1);
            if (ncs === 1'b0) begin
               if (prev_ncs) begin
                  if (gap_check) chk("gap_len", 32'(high_cnt), 32'(2 * D + 1));
                  edges   = 0;
                  low_cnt = 0;
                  shift   = 16'h0000;
               end
               high_cnt = 0;
               low_cnt++;
               if (sclk && !prev_sclk) begin
                  shift = {shift[14:0], copi};
                  edges++;
               end
               if (sclk && prev_sclk) chk("copi_stable_hi", 32'(copi), 32'(prev_copi));
            end else begin
               high_cnt++;
               chk("sclk_idle", 32'(sclk), 32'd0);
            end
            chk("done_pulse", 32'(done), 32'(ncs_rise));
            if (done === 1'b1) done_cnt++;
            if (ncs_rise) begin
               frames++;
               chk("copi_after", 32'(copi), 32'd0);
               chk("sclk_edges", 32'(edges), 32'd16);
               chk("ncs_low", 32'(low_cnt), 32'(33 * D));
               chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("frame", 32'(shift), 32'(e.frame));
                  chk("done_id", 32'(done_id), 32'(e.id));
               end
               got_ids.push_back(done_id);
               if (shift[14:8] < 7'd5) pregs[shift[10:8]] = shift[7:0];
            end
            prev_ncs  = ncs;
            prev_sclk = sclk;
            prev_copi = copi;
         end
      end
   end

   task automatic send(input logic use_b, input logic [6:0] addr, input logic [7:0] data);
      int c;
      int g0;
      c = 0;
      @(posedge clk); #1;
      g0 = grants;
      if (use_b) begin
         bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_data = data;
      end else begin
         bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_data = data;
      end
      while ((grants == g0) && (c < BUDGET)) begin
         @(posedge clk);
         c++;
      end
      #1;
      bus.a_valid = 1'b0; bus.a_addr = ~addr; bus.a_data = ~data;
      bus.b_valid = 1'b0; bus.b_addr = ~addr; bus.b_data = ~data;
      chk("accept_timeout", 32'(grants != g0), 32'd1);
   endtask

   task automatic wait_frames(input int n);
      int c;
      c = 0;
      while ((frames < n) && (c < BUDGET)) begin
         @(posedge clk);
         c++;
      end
      chk("frame_timeout", 32'(frames >= n), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Directed stimulus sequence.
   initial begin : stim
      int   f0;
      int   g0;
      int   d0;
      int   c;
      logic exp_ids [0:3];
      logic [7:0] dv;
      exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
      for (int i = 0; i < 5; i++) pregs[i] = 8'h00;
      bus.a_valid = 1'b0; bus.a_addr = 7'h00; bus.a_data = 8'h00;
      bus.b_valid = 1'b0; bus.b_addr = 7'h00; bus.b_data = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ncs", 32'(ncs), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_copi", 32'(copi), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_done_id", 32'(done_id), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Single A write 0x04/0xA5 -> frame 0x84A5 with exactly one done
      d0 = done_cnt;
      f0 = frames;
      send(1'b0, 7'h04, 8'hA5);
      wait_frames(f0 + 1);
      repeat (4 * D) @(posedge clk);
      chk("single_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Both requesters held valid -> A,B,A,B
      do_reset();
      got_ids.delete();
      f0 = frames;
      g0 = grants;
      @(posedge clk); #1;
      bus.a_valid = 1'b1; bus.a_addr = 7'h01; bus.a_data = 8'h3C;
      bus.b_valid = 1'b1; bus.b_addr = 7'h02; bus.b_data = 8'hC3;
      c = 0;
      while ((grants < g0 + 4) && (c < 4 * BUDGET)) begin
         @(posedge clk);
         c++;
      end
      #1;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      chk("rr_grants", 32'(grants - g0), 32'd4);
      wait_frames(f0 + 4);
      chk("rr_id_count", 32'(got_ids.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_ids.size()) chk("rr_done_id", 32'(got_ids[i]), 32'(exp_ids[i]));
      end

      // B held valid with addr 0x7F / data 0x00 -> 0xFF00 frames with minimal gaps
      f0 = frames;
      g0 = grants;
      @(posedge clk); #1;
      bus.b_valid = 1'b1; bus.b_addr = 7'h7F; bus.b_data = 8'h00;
      wait_frames(f0 + 1);
      gap_check = 1'b1;
      c = 0;
      while ((grants < g0 + 3) && (c < 4 * BUDGET)) begin
         @(posedge clk);
         c++;
      end
      #1 bus.b_valid = 1'b0;
      wait_frames(f0 + 3);
      gap_check = 1'b0;

      // Reset at the 7th SCLK rising edge aborts the frame
      f0 = frames;
      send(1'b0, 7'h15, 8'h5A);
      c = 0;
      while ((edges != 7) && (c < BUDGET)) begin
         @(posedge clk);
         c++;
      end
      chk("abort_reach_edge7", 32'(edges), 32'd7);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_ncs", 32'(ncs), 32'd1);
      chk("abort_sclk", 32'(sclk), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_no_done", 32'(done), 32'd0);
      end
      chk("abort_no_frame", 32'(frames), 32'(f0));
      send(1'b0, 7'h06, 8'h77);
      wait_frames(f0 + 1);

      // Write peripheral registers 0..4 through the SPI link
      f0 = frames;
      for (int i = 0; i < 5; i++) begin
         dv = 8'h11 * 8'(i + 1);
         send(1'b0, 7'(i), dv);
      end
      wait_frames(f0 + 5);
      chk("en_out", 32'({pregs[1], pregs[0]}), 32'h2211);
      chk("en_pwm", 32'({pregs[3], pregs[2]}), 32'h4433);
      chk("pwm_duty", 32'(pregs[4]), 32'h55);

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
